// File: rtl/argmax_seq_pkg.sv
// Shared binary32 constants and helpers for the
// sequential arg-max block.
package argmax_seq_pkg;

  localparam logic [7:0]  FP32_EXP_MAX   = 8'hFF;
  localparam logic [31:0] FP32_CANON_NAN = 32'h7FC0_0000;
  localparam logic [31:0] FP32_POS_ZERO  = 32'h0000_0000;
  localparam logic [31:0] FP32_NEG_ZERO  = 32'h8000_0000;

  function automatic logic fp32_is_nan(
    input logic [31:0] v
  );
    return (v[30:23] == FP32_EXP_MAX) &&
           (v[22:0] != 23'd0);
  endfunction

  function automatic logic fp32_is_zero(
    input logic [31:0] v
  );
    return (v | FP32_NEG_ZERO) == FP32_NEG_ZERO;
  endfunction

endpackage

// File: rtl/argmax_seq_float_greater.sv
// Combinational binary32 a > b; NaN on either
// side never yields greater, +0 equals -0.
module float_greater
  import argmax_seq_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        gt
);

  logic        a_nan;
  logic        b_nan;
  logic        both_zero;
  logic        sa;
  logic        sb;
  logic [30:0] ma;
  logic [30:0] mb;

  assign a_nan     = fp32_is_nan(a);
  assign b_nan     = fp32_is_nan(b);
  assign both_zero = fp32_is_zero(a) &&
                     fp32_is_zero(b);
  assign sa        = a[31];
  assign sb        = b[31];
  assign ma        = a[30:0];
  assign mb        = b[30:0];

  // Sign-magnitude ordering: negatives flip.
  always_comb begin
    gt = 1'b0;
    if (a_nan || b_nan) begin
      gt = 1'b0;
    end else if (both_zero) begin
      gt = 1'b0;
    end else if (!sa && !sb) begin
      gt = ma > mb;
    end else if (sa && sb) begin
      gt = ma < mb;
    end else begin
      gt = !sa;
    end
  end

endmodule

// File: rtl/argmax_seq.sv
// Sequential arg-max over a packed binary32
// vector, one element compared per clock.
module argmax_seq
  import argmax_seq_pkg::*;
#(
  parameter  int VLEN  = 10,
  localparam int IDX_W = (VLEN > 1) ?
                         $clog2(VLEN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [32*VLEN-1:0] in,
  input  logic              start,
  output logic [IDX_W-1:0]  index,
  output logic [31:0]       max_value,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(VLEN - 1);
  localparam logic [IDX_W-1:0] ONE =
    IDX_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic             start_q;
  logic [31:0]      vec_q [VLEN];
  logic [31:0]      cand_q;
  logic [31:0]      cand_d;
  logic [IDX_W-1:0] cand_idx_q;
  logic [IDX_W-1:0] cand_idx_d;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] index_d;
  logic [31:0]      max_d;
  logic             busy_d;
  logic             done_d;
  logic             load;

  logic             start_edge;
  logic [31:0]      elem;
  logic             elem_nan;
  logic             cand_nan;
  logic             elem_gt;
  logic             take;
  logic [31:0]      fin;
  logic [31:0]      first;

  assign start_edge = start && !start_q &&
                      (state_q != SCAN);
  assign elem       = vec_q[ptr_q];
  assign elem_nan   = fp32_is_nan(elem);
  assign cand_nan   = fp32_is_nan(cand_q);
  assign first      = in[31:0];

  float_greater u_gt (
    .a  (elem),
    .b  (cand_q),
    .gt (elem_gt)
  );

  // A NaN candidate yields to any real value.
  assign take = cand_nan ? !elem_nan : elem_gt;
  assign fin  = take ? elem : cand_q;

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cand_idx_d = cand_idx_q;
    ptr_d      = ptr_q;
    index_d    = index;
    max_d      = max_value;
    busy_d     = busy;
    done_d     = done;
    load       = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_edge) begin
          load       = 1'b1;
          cand_d     = first;
          cand_idx_d = '0;
          ptr_d      = ONE;
          done_d     = 1'b0;
          if (VLEN == 1) begin
            state_d = DONE;
            done_d  = 1'b1;
            index_d = '0;
            max_d   = fp32_is_nan(first) ?
                      FP32_CANON_NAN : first;
          end else begin
            state_d = SCAN;
            busy_d  = 1'b1;
          end
        end
      end
      SCAN: begin
        if (take) begin
          cand_d     = elem;
          cand_idx_d = ptr_q;
        end
        if (ptr_q == LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          index_d = take ? ptr_q : cand_idx_q;
          max_d   = fp32_is_nan(fin) ?
                    FP32_CANON_NAN : fin;
        end else begin
          ptr_d = ptr_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      cand_q     <= FP32_POS_ZERO;
      cand_idx_q <= '0;
      ptr_q      <= '0;
      index      <= '0;
      max_value  <= FP32_POS_ZERO;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      cand_q     <= cand_d;
      cand_idx_q <= cand_idx_d;
      ptr_q      <= ptr_d;
      index      <= index_d;
      max_value  <= max_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Snapshot so later changes on in are ignored.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < VLEN; i++) begin
        vec_q[i] <= in[32*i +: 32];
      end
    end
  end

endmodule

// File: tb/tb_argmax_seq.sv
// Directed bench for argmax_seq at VLEN 1, 2,
// 4 and 8.
module tb_argmax_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic [127:0] in4 = '0;
  logic         s4 = 1'b0;
  logic [1:0]   idx4;
  logic [31:0]  mv4;
  logic         busy4;
  logic         done4;

  logic [63:0]  in2 = '0;
  logic         s2 = 1'b0;
  logic [0:0]   idx2;
  logic [31:0]  mv2;
  logic         busy2;
  logic         done2;

  logic [255:0] in8 = '0;
  logic         s8 = 1'b0;
  logic [2:0]   idx8;
  logic [31:0]  mv8;
  logic         busy8;
  logic         done8;

  logic [31:0]  in1 = '0;
  logic         s1 = 1'b0;
  logic [0:0]   idx1;
  logic [31:0]  mv1;
  logic         busy1;
  logic         done1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  argmax_seq #(.VLEN(4)) u4 (
    .clk(clk), .rst(rst), .in(in4),
    .start(s4), .index(idx4),
    .max_value(mv4), .busy(busy4),
    .done(done4)
  );

  argmax_seq #(.VLEN(2)) u2 (
    .clk(clk), .rst(rst), .in(in2),
    .start(s2), .index(idx2),
    .max_value(mv2), .busy(busy2),
    .done(done2)
  );

  argmax_seq #(.VLEN(8)) u8 (
    .clk(clk), .rst(rst), .in(in8),
    .start(s8), .index(idx8),
    .max_value(mv8), .busy(busy8),
    .done(done8)
  );

  argmax_seq #(.VLEN(1)) u1 (
    .clk(clk), .rst(rst), .in(in1),
    .start(s1), .index(idx1),
    .max_value(mv1), .busy(busy1),
    .done(done1)
  );

  typedef struct {
    logic [127:0] v;
    logic [1:0]   ix;
    logic [31:0]  mv;
  } vec4_t;

  vec4_t tbl[7];

  task automatic chk(
    input string       name,
    input logic [31:0] got,
    input logic [31:0] want
  );
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               name, got, want);
    end
  endtask

  task automatic sig(
    input  int          sel,
    output logic        b,
    output logic        d,
    output logic [31:0] ix,
    output logic [31:0] mv
  );
    case (sel)
      1: begin
        b = busy1; d = done1;
        ix = 32'(idx1); mv = mv1;
      end
      2: begin
        b = busy2; d = done2;
        ix = 32'(idx2); mv = mv2;
      end
      8: begin
        b = busy8; d = done8;
        ix = 32'(idx8); mv = mv8;
      end
      default: begin
        b = busy4; d = done4;
        ix = 32'(idx4); mv = mv4;
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(
    input  int   sel,
    input  int   lim,
    output int   edges,
    output int   busy_n,
    output logic ok
  );
    logic b, d;
    logic [31:0] ix, mv;
    edges = 0;
    busy_n = 0;
    ok = 1'b0;
    for (int e = 1; e <= lim; e++) begin
      step();
      sig(sel, b, d, ix, mv);
      edges = e;
      if (b) busy_n++;
      if (d) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_out(
    input string       tag,
    input int          sel,
    input logic [31:0] ix_w,
    input logic [31:0] mv_w
  );
    logic b, d;
    logic [31:0] ix, mv;
    sig(sel, b, d, ix, mv);
    chk({tag, " index"}, ix, ix_w);
    chk({tag, " max"}, mv, mv_w);
  endtask

  task automatic run4(input int k);
    int edges, bn;
    logic ok;
    string tag;
    tag = $sformatf("vec4[%0d]", k);
    in4 = tbl[k].v;
    s4 = 1'b1;
    wait_done(4, 8, edges, bn, ok);
    chk({tag, " done"}, 32'(ok), 32'd1);
    chk({tag, " latency"}, edges, 4);
    chk({tag, " busy"}, bn, 3);
    check_out(tag, 4, 32'(tbl[k].ix),
              tbl[k].mv);
    s4 = 1'b0;
    step();
  endtask

  logic [255:0] v8;
  int   edges, bn, rises;
  logic ok, prevb;

  initial begin
    tbl[0] = '{{32'h3F000000, 32'hC0000000,
                32'h40600000, 32'h3F800000},
               2'd1, 32'h40600000};
    tbl[1] = '{{32'hC0400000, 32'hBF000000,
                32'hBF000000, 32'hBF800000},
               2'd1, 32'hBF000000};
    tbl[2] = '{{32'h7F800000, 32'h40000000,
                32'hFF800000, 32'h7FC00001},
               2'd3, 32'h7F800000};
    tbl[3] = '{{32'h7FFFFFFF, 32'hFFC00000,
                32'h7F800001, 32'h7FC00001},
               2'd0, 32'h7FC00000};
    tbl[4] = '{{32'h00000002, 32'h80000005,
                32'h00000003, 32'h00000001},
               2'd1, 32'h00000003};
    tbl[5] = '{{32'hFF800000, 32'hBF800000,
                32'hC0000000, 32'hFFC00000},
               2'd2, 32'hBF800000};
    tbl[6] = '{{32'h3F800000, 32'h3F800000,
                32'h3F800000, 32'h3F800000},
               2'd0, 32'h3F800000};
    v8 = {32'h3F800000, 32'hFF800000,
          32'h7F7FFFFF, 32'h41200000,
          32'h7FC00000, 32'h41200000,
          32'hC1200000, 32'h40000000};

    // Reset, with u1 start held high throughout
    in1 = 32'hC2C80000;
    s1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_out("reset u4", 4, 32'd0, 32'd0);
    chk("reset busy4", 32'(busy4), 32'd0);
    chk("reset done4", 32'(done4), 32'd0);
    chk("reset done1", 32'(done1), 32'd0);
    rst = 1'b0;

    wait_done(1, 4, edges, bn, ok);
    chk("v1 done", 32'(ok), 32'd1);
    chk("v1 latency", edges, 1);
    chk("v1 busy", bn, 0);
    check_out("v1", 1, 32'd0, 32'hC2C80000);
    s1 = 1'b0;
    step();
    in1 = 32'h7F800001;
    s1 = 1'b1;
    wait_done(1, 4, edges, bn, ok);
    chk("v1 nan latency", edges, 1);
    check_out("v1 nan", 1, 32'd0, 32'h7FC00000);
    s1 = 1'b0;
    step();

    for (int k = 0; k < 7; k++) run4(k);

    // Start held high: exactly one run
    in4 = tbl[0].v;
    s4 = 1'b1;
    prevb = 1'b0;
    rises = 0;
    repeat (10) begin
      step();
      if (busy4 && !prevb) rises++;
      prevb = busy4;
    end
    chk("hold runs", rises, 1);
    chk("hold done", 32'(done4), 32'd1);
    check_out("hold", 4, 32'd1, 32'h40600000);
    s4 = 1'b0;
    step();

    // Re-trigger during SCAN is ignored
    in4 = tbl[0].v;
    s4 = 1'b1;
    step();
    s4 = 1'b0;
    step();
    s4 = 1'b1;
    step();
    wait_done(4, 6, edges, bn, ok);
    chk("retrig latency", edges, 1);
    check_out("retrig", 4, 32'd1, 32'h40600000);
    repeat (4) step();
    chk("retrig no rerun done", 32'(done4), 32'd1);
    chk("retrig no rerun busy", 32'(busy4), 32'd0);
    s4 = 1'b0;
    step();

    // Input change mid-scan is ignored
    in4 = tbl[0].v;
    s4 = 1'b1;
    step();
    step();
    in4 = tbl[2].v;
    wait_done(4, 6, edges, bn, ok);
    chk("midin latency", edges, 2);
    check_out("midin", 4, 32'd1, 32'h40600000);
    s4 = 1'b0;
    step();

    // New edge from DONE
    in4 = tbl[1].v;
    s4 = 1'b1;
    step();
    chk("redo done drop", 32'(done4), 32'd0);
    chk("redo busy", 32'(busy4), 32'd1);
    wait_done(4, 6, edges, bn, ok);
    chk("redo latency", edges, 3);
    check_out("redo", 4, 32'd1, 32'hBF000000);
    s4 = 1'b0;
    step();

    // Signed zeros, VLEN=2
    in2 = {32'h80000000, 32'h00000000};
    s2 = 1'b1;
    wait_done(2, 6, edges, bn, ok);
    chk("zero latency", edges, 2);
    check_out("zero +-", 2, 32'd0, 32'h00000000);
    s2 = 1'b0;
    step();
    in2 = {32'h00000000, 32'h80000000};
    s2 = 1'b1;
    wait_done(2, 6, edges, bn, ok);
    check_out("zero -+", 2, 32'd0, 32'h80000000);
    s2 = 1'b0;
    step();

    // VLEN=8 full run, then reset mid-scan
    in8 = v8;
    s8 = 1'b1;
    wait_done(8, 12, edges, bn, ok);
    chk("v8 latency", edges, 8);
    chk("v8 busy", bn, 7);
    check_out("v8", 8, 32'd5, 32'h7F7FFFFF);
    s8 = 1'b0;
    step();
    s8 = 1'b1;
    step();
    step();
    step();
    rst = 1'b1;
    s8 = 1'b0;
    step();
    chk("rst busy8", 32'(busy8), 32'd0);
    chk("rst done8", 32'(done8), 32'd0);
    check_out("rst v8", 8, 32'd0, 32'd0);
    rst = 1'b0;
    step();
    s8 = 1'b1;
    wait_done(8, 12, edges, bn, ok);
    chk("v8 again latency", edges, 8);
    check_out("v8 again", 8, 32'd5,
              32'h7F7FFFFF);
    s8 = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/argmax_seq.md
Name: argmax_seq

Overview:
- Sequential arg-max over a vector of IEEE-754 binary32 values.
- Sits directly downstream of the sequential neural layer. It consumes the layer's packed `result` vector and its level `done`, and produces the index of the largest element as a classification output.
- Compares one element per clock, so it needs only a single float comparator regardless of vector length.

Parameters:
- VLEN, 10, number of 32-bit elements in the input vector (>= 1).
- IDX_W, derived localparam, max(1, $clog2(VLEN)), width of the index output.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- in  in  32*VLEN  packed float vector; element i is `in[32*i +: 32]`.
- start  in  1  level input, normally tied to the layer's `done`. A rising edge triggers a run.
- index  out  IDX_W  position of the maximum element.
- max_value  out  32  value of the maximum element.
- busy  out  1  high while scanning.
- done  out  1  high while index/max_value are valid for the last run.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - index=0, max_value=0, busy=0, done=0.
  - FSM in IDLE.
  - start_q (previous-start register) = 0. If start is held high through reset, a run begins on the first cycle after reset.
- Start edge: the cycle where start=1 and start_q=0, with FSM in IDLE or DONE.
  - A start edge seen in SCAN is ignored and not queued.
- FSM states: IDLE, SCAN, DONE.
  - IDLE/DONE + start edge:
    - Latch the full `in` into an internal vector register; later changes on `in` have no effect.
    - Load candidate = element 0, cand_idx = 0, ptr = 1.
    - done<=0.
    - If VLEN==1, go to DONE; else go to SCAN with busy<=1.
  - SCAN: each cycle compare element[ptr] against the candidate.
    - Replace the candidate only if element[ptr] is strictly greater.
    - If ptr==VLEN-1: go to DONE, busy<=0, done<=1, and update index/max_value from the final candidate. Otherwise ptr<=ptr+1.
  - DONE: outputs held; done stays high until the next start edge.
- Latency: with the start edge sampled at clock edge k, done=1 and outputs are valid after edge k+VLEN (k+1 when VLEN=1).
- index and max_value update only on entry to DONE; they hold their previous values during SCAN.
- Comparison rules (binary32):
  - NaN is exp=0xFF with mant!=0. NaN never wins and never displaces the candidate.
  - A NaN candidate is displaced by any non-NaN value.
  - +0 and -0 compare equal.
  - ±Inf are ordered normally.
  - Denormals are ordered by bit pattern, with no flush.
  - Ordering for non-NaN values: both positive compares the magnitude bits ascending; both negative compares magnitude descending; positive is greater than negative (except the zero case above).
- Ties: strict greater-than, so the lowest index wins.
- All elements NaN: index=0, max_value=0x7FC00000 (canonical NaN).
- rst asserted mid-SCAN: next cycle is IDLE with reset values, and the partial result is discarded.

Decomposition:
- Include-guarded shared header `src/FloatConsts.vh`:
  - FP32_EXP_MAX (8'hFF).
  - FP32_CANON_NAN (32'h7FC00000).
  - FP32_POS_ZERO / FP32_NEG_ZERO.
  - Macro for the NaN test.
- FSM state encodings are localparams inside the module.
- One sub-module, `float_greater`: combinational, inputs a/b [31:0], output gt = (a > b) under the rules above, treating NaN a as never greater. The NaN-candidate displacement is handled in argmax_seq.

Test Plan:
- VLEN=4, in={1.0,3.5,-2.0,0.5} (0x3F800000, 0x40600000, 0xC0000000, 0x3F000000), start rises at edge k -> done=1 at edge k+4, index=1, max_value=0x40600000, busy high edges k+1..k+3.
- Tie and negatives: VLEN=4, in={-1.0,-0.5,-0.5,-3.0} -> index=1, max_value=0xBF000000. Separately, {+0, -0} (VLEN=2, 0x00000000, 0x80000000) -> index=0.
- NaN/Inf handling, VLEN=4:
  - {NaN 0x7FC00001, -Inf 0xFF800000, 2.0, +Inf 0x7F800000} -> index=3, max_value=0x7F800000.
  - All four elements NaN -> index=0, max_value=0x7FC00000.
- Protocol, VLEN=4:
  - Hold start high for 10 cycles -> exactly one run.
  - Toggle start 0->1 during SCAN -> ignored; result matches the first vector.
  - Change `in` mid-scan -> no effect.
  - New rising edge while in DONE -> done drops the next cycle; the new result appears 4 edges later.
- Reset mid-SCAN (VLEN=8, rst at the 3rd scan cycle) -> next edge busy=0, done=0, index=0, max_value=0. A subsequent start edge gives a correct full result.
- VLEN=1, in={0xC2C80000 (-100.0)} -> done after 1 edge, index=0, max_value=0xC2C80000, busy never asserted.
